cam_tlb: RTL

Parametrised, fully associative translation CAM. It replaces the fixed 8-bit-key, fixed-depth CAM.
- Key is {vpn, pid}. Stored data is the physical page address.
- Adds in-place update on a write hit, round-robin replacement when full, and flush commands (by PID, or all).
- Adds occupancy, full and evict status.
- Sits between the address-generation logic and memory. Driven by a single command port with an outrdy handshake.

---
 rtl/cam_tlb_pkg.sv | 23 ++
 rtl/cam_tlb_match.sv | 37 +++
 rtl/cam_tlb.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/cam_tlb_pkg.sv
// Shared encodings for the translation CAM: command codes, FSM states and
// the occupancy counter width.
package cam_tlb_pkg;

  localparam logic [2:0] CMD_NOP       = 3'd0;
  localparam logic [2:0] CMD_WRITE     = 3'd1;
  localparam logic [2:0] CMD_DELETE    = 3'd2;
  localparam logic [2:0] CMD_READ      = 3'd3;
  localparam logic [2:0] CMD_FLUSH_PID = 3'd4;
  localparam logic [2:0] CMD_FLUSH_ALL = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Wide enough to hold the value DEPTH itself, not just DEPTH-1.
  function automatic int occ_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/cam_tlb_match.sv
// Combinational search across all entries: exact key match, pid match for
// flushes, and the lowest free slot for allocation.
module cam_tlb_match
  import cam_tlb_pkg::*;
#(
  parameter  int DEPTH = 16,
  parameter  int KEY_W = 8,
  parameter  int PID_W = 4,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0][KEY_W-1:0] keys,
  input  logic [DEPTH-1:0]            valid,
  input  logic [KEY_W-1:0]            search_key,
  input  logic [PID_W-1:0]            search_pid,
  output logic                        hit,
  output logic [DEPTH-1:0]            match,
  output logic [DEPTH-1:0]            pid_match,
  output logic [IDX_W-1:0]            free_idx,
  output logic                        any_free
);

  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    assign match[i]     = valid[i] && (keys[i] == search_key);
    assign pid_match[i] = valid[i] && (keys[i][PID_W-1:0] == search_pid);
  end

  assign hit      = |match;
  assign any_free = ~&valid;

  // Scan from the top so the lowest invalid index wins.
  always_comb begin
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--)
      if (!valid[i]) free_idx = IDX_W'(i);
  end

endmodule

// File: rtl/cam_tlb.sv
// Fully associative {vpn,pid} -> page translation CAM with a single command
// port, round-robin replacement when full, and pid/global flush.
module cam_tlb
  import cam_tlb_pkg::*;
#(
  parameter  int VPN_W  = 4,
  parameter  int PID_W  = 4,
  parameter  int DATA_W = 8,
  parameter  int DEPTH  = 16,
  localparam int KEY_W  = VPN_W + PID_W,
  localparam int OCC_W  = occ_width(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        cmd,
  input  logic [KEY_W-1:0]  key,
  input  logic [DATA_W-1:0] datain,
  output logic [DATA_W-1:0] dataout,
  output logic              outvalid,
  output logic              pagefault,
  output logic              outrdy,
  output logic              full,
  output logic              evict,
  output logic [OCC_W-1:0]  occupancy
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [DEPTH-1:0][KEY_W-1:0]  keys;
  logic [DEPTH-1:0][DATA_W-1:0] data;
  logic [DEPTH-1:0]             valid, valid_nxt;
  logic [IDX_W-1:0]             ptr, ptr_nxt;
  state_t                       state;

  logic [2:0]        op;
  logic [KEY_W-1:0]  op_key;
  logic [DATA_W-1:0] op_data;

  logic              hit, any_free;
  logic [DEPTH-1:0]  match, pid_match;
  logic [IDX_W-1:0]  free_idx, hit_idx, wr_idx;
  logic              wr_en, evict_nxt, accept;
  logic [OCC_W-1:0]  occ_nxt;

  // Codes 6/7 decode as NOP and are never accepted.
  assign accept = outrdy && (cmd >= CMD_WRITE) && (cmd <= CMD_FLUSH_ALL);

  cam_tlb_match #(
    .DEPTH (DEPTH),
    .KEY_W (KEY_W),
    .PID_W (PID_W)
  ) u_match (
    .keys       (keys),
    .valid      (valid),
    .search_key (op_key),
    .search_pid (op_key[PID_W-1:0]),
    .hit        (hit),
    .match      (match),
    .pid_match  (pid_match),
    .free_idx   (free_idx),
    .any_free   (any_free)
  );

  always_comb begin
    hit_idx = '0;
    for (int i = 0; i < DEPTH; i++)
      if (match[i]) hit_idx = IDX_W'(i);
  end

  // Array update decided in EXEC: hit overwrites in place, miss fills the
  // lowest free slot, and only a full miss evicts at the victim pointer.
  always_comb begin
    valid_nxt = valid;
    ptr_nxt   = ptr;
    wr_en     = 1'b0;
    wr_idx    = hit_idx;
    evict_nxt = 1'b0;
    if (state == ST_EXEC) begin
      case (op)
        CMD_WRITE: begin
          wr_en = 1'b1;
          if (hit) begin
            wr_idx = hit_idx;
          end else if (any_free) begin
            wr_idx = free_idx;
          end else begin
            wr_idx    = ptr;
            evict_nxt = 1'b1;
            ptr_nxt   = (ptr == IDX_W'(DEPTH - 1)) ? '0 : ptr + IDX_W'(1);
          end
          valid_nxt[wr_idx] = 1'b1;
        end
        CMD_DELETE:    valid_nxt = valid & ~match;
        CMD_FLUSH_PID: valid_nxt = valid & ~pid_match;
        CMD_FLUSH_ALL: begin
          valid_nxt = '0;
          ptr_nxt   = '0;
        end
        default: ;
      endcase
    end
    occ_nxt = '0;
    for (int i = 0; i < DEPTH; i++)
      occ_nxt = occ_nxt + OCC_W'(valid_nxt[i]);
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      keys[wr_idx] <= op_key;
      data[wr_idx] <= op_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      outrdy    <= 1'b1;
      op        <= CMD_NOP;
      op_key    <= '0;
      op_data   <= '0;
      valid     <= '0;
      ptr       <= '0;
      occupancy <= '0;
      full      <= 1'b0;
      dataout   <= '0;
      outvalid  <= 1'b0;
      pagefault <= 1'b0;
      evict     <= 1'b0;
    end else begin
      outvalid  <= 1'b0;
      pagefault <= 1'b0;
      evict     <= evict_nxt;
      valid     <= valid_nxt;
      ptr       <= ptr_nxt;
      occupancy <= occ_nxt;
      full      <= (occ_nxt == OCC_W'(DEPTH));
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state   <= ST_EXEC;
            outrdy  <= 1'b0;
            op      <= cmd;
            op_key  <= key;
            op_data <= datain;
          end
        end
        ST_EXEC: begin
          if (op == CMD_READ || op == CMD_DELETE) begin
            state <= ST_RESP;
          end else begin
            state  <= ST_IDLE;
            outrdy <= 1'b1;
          end
          if (op == CMD_READ) begin
            if (hit) begin
              outvalid <= 1'b1;
              dataout  <= data[hit_idx];
            end else begin
              pagefault <= 1'b1;
            end
          end
          if (op == CMD_DELETE && !hit) pagefault <= 1'b1;
        end
        ST_RESP: begin
          state  <= ST_IDLE;
          outrdy <= 1'b1;
        end
        default: begin
          state  <= ST_IDLE;
          outrdy <= 1'b1;
        end
      endcase
    end
  end

endmodule
